pattern_detector: RTL and testbench

PATTERN_DETECTOR -- requirements
Module: pattern_detector

---
 rtl/pattern_detector_pkg.sv | 5 +
 rtl/sat_counter.sv | 16 +
 rtl/pattern_detector.sv | 56 +++++
 tb/tb_pattern_detector.sv | 126 ++++++++++++
 4 files changed

// File: rtl/pattern_detector_pkg.sv
// pattern_detector_pkg: shared FSM state encoding and default pattern for pattern_detector.
package pattern_detector_pkg;
  typedef enum logic {SCAN = 1'b0, HIT = 1'b1} state_t;
  localparam logic [3:0] PD_DEF_PAT = 4'b1001;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter; a clear restarts from the same-edge increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clock) begin
    if (reset) count <= '0;
    else if (clr) count <= CNT_W'(inc);
    else if (inc && count != '1) count <= count + 1'b1;
  end
endmodule

// File: rtl/pattern_detector.sv
// pattern_detector: serial pattern matcher with Moore match flag and saturating match counter.
module pattern_detector
  import pattern_detector_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(PD_DEF_PAT),
  parameter int               CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             I,
  input  logic             in_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             F,
  output logic [CNT_W-1:0] match_count
);
  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);
  logic [PAT_W-1:0] r_pat, r_hist, w_hist_next;
  logic [FW-1:0]    r_fill, w_fill_next;
  logic             w_match;
  state_t           r_state, w_state_next;
  assign w_hist_next = {r_hist[PAT_W-2:0], I};
  assign w_fill_next = (r_fill == FULL) ? FULL : r_fill + 1'b1;
  // a pattern load discards the bit sampled on the same edge
  assign w_match = in_valid && !pat_load && w_fill_next == FULL && w_hist_next == r_pat;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pat  <= DEF_PAT;
      r_hist <= '0;
      r_fill <= '0;
    end else if (pat_load) begin
      r_pat  <= pat_in;
      r_fill <= '0;
    end else if (in_valid) begin
      r_hist <= w_hist_next;
      r_fill <= (w_match && !overlap) ? '0 : w_fill_next;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) r_state <= SCAN;
    else r_state <= w_state_next;
  end
  always_comb w_state_next = w_match ? HIT : SCAN;
  always_comb F = (r_state == HIT);
  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clock(clock),
    .reset(reset),
    .inc(w_match),
    .clr(cnt_clr),
    .count(match_count)
  );
endmodule

// File: tb/tb_pattern_detector.sv
// tb_pattern_detector: randomized + directed scoreboard bench against a bit-list reference model.
module tb_pattern_detector;
  typedef struct {
    int f;
    int c8;
    int c2;
  } exp_t;
  logic clock = 0, reset = 0, I = 0, in_valid = 0, overlap = 0, pat_load = 0, cnt_clr = 0;
  logic [3:0] pat_in = '0;
  logic F, F2;
  logic [7:0] match_count;
  logic [1:0] mc2;
  exp_t exp_q[$];
  bit   mq[$];
  logic [3:0] mpat = 4'b1001;
  int c8 = 0, c2 = 0;
  int n_chk = 0, n_fail = 0;

  pattern_detector dut (
    .clock(clock), .reset(reset), .I(I), .in_valid(in_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr), .F(F), .match_count(match_count)
  );
  pattern_detector #(.CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .I(I), .in_valid(in_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr), .F(F2), .match_count(mc2)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] last4();
    logic [3:0] r = '0;
    foreach (mq[i]) r = {r[2:0], mq[i]};
    return r;
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, want, $time);
    end
  endtask

  // drive one cycle and push the reference model's view of the following cycle
  task automatic step(input logic rs, input logic v, input logic b, input logic ov,
                      input logic ld, input logic [3:0] pin, input logic cl);
    bit m = 0;
    @(negedge clock);
    reset = rs; in_valid = v; I = b; overlap = ov; pat_load = ld; pat_in = pin; cnt_clr = cl;
    if (rs) begin
      mpat = 4'b1001; mq.delete(); c8 = 0; c2 = 0;
    end else begin
      if (ld) begin
        mpat = pin; mq.delete();
      end else if (v) begin
        mq.push_back(b);
        if (mq.size() > 4) mq = mq[1:$];
        if (mq.size() == 4 && last4() == mpat) begin
          m = 1;
          if (!ov) mq.delete();
        end
      end
      c8 = cl ? int'(m) : (m && c8 < 255) ? c8 + 1 : c8;
      c2 = cl ? int'(m) : (m && c2 < 3) ? c2 + 1 : c2;
    end
    exp_q.push_back('{f: int'(m), c8: c8, c2: c2});
  endtask

  task automatic feed(input logic [15:0] seq, input int n, input logic ov);
    for (int k = n - 1; k >= 0; k--) step(0, 1, seq[k], ov, 0, 4'h0, 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 1, 0, 4'h0, 0);
  endtask

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("F", int'(F), e.f);
      chk("F_cnt2", int'(F2), e.f);
      chk("match_count", int'(match_count), e.c8);
      chk("match_count_cnt2", int'(mc2), e.c2);
    end
  end

  initial begin
    step(1, 0, 0, 1, 0, 4'h0, 0);
    step(1, 1, 1, 1, 1, 4'hF, 1);
    feed(16'b1001, 4, 1);
    idle(2);
    step(0, 1, 0, 1, 1, 4'b1111, 0);
    feed(16'b111111, 6, 1);
    step(0, 0, 0, 0, 1, 4'b1111, 0);
    feed(16'b111111, 6, 0);
    idle(1);
    step(0, 0, 0, 1, 1, 4'b1001, 0);
    feed(16'b10, 2, 1);
    idle(3);
    feed(16'b01, 2, 1);
    feed(16'b011, 3, 1);
    step(0, 1, 0, 1, 1, 4'b0110, 0);
    feed(16'b110, 3, 1);
    feed(16'b0110, 4, 1);
    step(0, 0, 0, 1, 1, 4'b1111, 0);
    feed(16'b11111111, 8, 1);
    step(0, 1, 1, 1, 0, 4'h0, 1);
    idle(1);
    step(1, 0, 0, 1, 0, 4'h0, 0);
    feed(16'b100, 3, 1);
    step(1, 0, 0, 1, 0, 4'h0, 0);
    feed(16'b1, 1, 1);
    feed(16'b1001, 4, 1);
    idle(2);
    for (int k = 0; k < 3000; k++)
      step($urandom_range(199) == 0, $urandom_range(3) != 0, 1'($urandom), $urandom_range(7) != 0,
           $urandom_range(39) == 0, 4'($urandom), $urandom_range(49) == 0);
    idle(1);
    repeat (3) @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
